// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared defaults, FSM state type and address type for the
//               multi-read-port register file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    typedef enum logic [0:0] {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_e;

    typedef logic [$clog2(NREGS_DEFAULT)-1:0] rf_addr_t;

endpackage

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ============================================================================
// Module      : regfile_scoreboard
// Description : Per-register pending-write bits with issue/writeback update
//               and per-read-port busy lookup.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEFAULT,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_run,
    input  logic              i_issue_valid,
    input  logic [AW-1:0]     i_issue_rd,
    input  logic              i_wb_en,
    input  logic [AW-1:0]     i_wb_addr,
    input  logic [NRD*AW-1:0] i_rd_addr,
    input  logic [NRD-1:0]    i_bypass_hit,
    output logic [NRD-1:0]    o_rd_busy
);

    logic [NREGS-1:0] r_pending;

    // Set is tested first so a same-cycle issue keeps the bit for the younger instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (i_run) begin
            for (int i = 1; i < NREGS; i++) begin
                if (i_issue_valid && (i_issue_rd == i[AW-1:0])) begin
                    r_pending[i] <= 1'b1;
                end else if (i_wb_en && (i_wb_addr == i[AW-1:0])) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    generate
        for (genvar p = 0; p < NRD; p++) begin : g_port
            logic [AW-1:0] w_addr;
            assign w_addr       = i_rd_addr[p*AW +: AW];
            assign o_rd_busy[p] = i_run && (w_addr != '0) && r_pending[w_addr] && !i_bypass_hit[p];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/register_file_mp.sv
// ============================================================================
// Module      : register_file_mp
// Description : Multi-read-port register file with post-reset clear sequence,
//               pending-write scoreboard and optional writeback bypass
//               (enabled by defining REGFILE_BYPASS_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEFAULT,
    parameter  int NREGS = NREGS_DEFAULT,
    parameter  int NRD   = 2,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NRD*AW-1:0]   rd_addr_i,
    output logic [NRD*XLEN-1:0] rd_data_o,
    output logic [NRD-1:0]      rd_busy_o,
    input  logic                issue_valid_i,
    input  logic [AW-1:0]       issue_rd_i,
    input  logic                wr_en_i,
    input  logic [AW-1:0]       wr_addr_i,
    input  logic [XLEN-1:0]     wr_data_i,
    output logic                init_busy_o
);

    localparam logic [AW-1:0] C_LAST = AW'(NREGS - 1);

    rf_state_e       r_state;
    logic [AW-1:0]   r_clr_cnt;
    logic [XLEN-1:0] r_mem [NREGS];
    logic            w_run;
    logic [NRD-1:0]  w_hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= RF_INIT;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                RF_INIT: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == C_LAST) begin
                        r_state <= RF_RUN;
                    end
                end
                RF_RUN:  r_state <= RF_RUN;
                default: r_state <= RF_INIT;
            endcase
        end
    end

    // Storage has no reset of its own; the clear sequence zeroes it entry by entry.
    always_ff @(posedge clk) begin
        if (r_state == RF_INIT) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (wr_en_i && (wr_addr_i != '0)) begin
            r_mem[wr_addr_i] <= wr_data_i;
        end
    end

    assign w_run       = (r_state == RF_RUN);
    assign init_busy_o = (r_state == RF_INIT);

    generate
        for (genvar p = 0; p < NRD; p++) begin : g_rd
            logic [AW-1:0] w_addr;
            assign w_addr = rd_addr_i[p*AW +: AW];
`ifdef REGFILE_BYPASS_EN
            assign w_hit[p] = w_run && wr_en_i && (wr_addr_i == w_addr) && (w_addr != '0);
`else
            assign w_hit[p] = 1'b0;
`endif
            assign rd_data_o[p*XLEN +: XLEN] = (!w_run || (w_addr == '0)) ? '0 :
                                               w_hit[p] ? wr_data_i : r_mem[w_addr];
        end
    endgenerate

    regfile_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD)
    ) u_scoreboard (
        .clk           (clk),
        .rst_n         (reset),
        .i_run         (w_run),
        .i_issue_valid (issue_valid_i),
        .i_issue_rd    (issue_rd_i),
        .i_wb_en       (wr_en_i),
        .i_wb_addr     (wr_addr_i),
        .i_rd_addr     (rd_addr_i),
        .i_bypass_hit  (w_hit),
        .o_rd_busy     (rd_busy_o)
    );

endmodule

`default_nettype wire

// File: tb/tb_register_file_mp.sv
// ============================================================================
// Module      : tb_register_file_mp
// Description : Self-checking bench for register_file_mp against a
//               behavioural model (REGFILE_BYPASS_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                issue_valid = 1'b0;
    logic [AW-1:0]       issue_rd = '0;
    logic                wr_en = 1'b0;
    logic [AW-1:0]       wr_addr = '0;
    logic [XLEN-1:0]     wr_data = '0;
    logic                init_busy;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    // Behavioural model: number of clear edges done, register contents, pending flags.
    int              m_done = 0;
    logic [XLEN-1:0] m_mem [NREGS];
    bit              m_pend [NREGS];

    register_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
        .clk           (clk),
        .reset         (reset),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .rd_busy_o     (rd_busy),
        .issue_valid_i (issue_valid),
        .issue_rd_i    (issue_rd),
        .wr_en_i       (wr_en),
        .wr_addr_i     (wr_addr),
        .wr_data_i     (wr_data),
        .init_busy_o   (init_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_done = 0;
            for (int i = 0; i < NREGS; i++) m_pend[i] = 1'b0;
        end else if (m_done < NREGS) begin
            m_mem[m_done] = '0;
            m_done++;
        end else begin
            if (wr_en && wr_addr != 0) begin
                m_mem[wr_addr]  = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
        end
    end

    function automatic bit m_hit(input logic [AW-1:0] a);
        return BYP && (m_done == NREGS) && wr_en && (wr_addr == a) && (a != 0);
    endfunction

    function automatic logic [XLEN-1:0] m_data(input logic [AW-1:0] a);
        if (m_done != NREGS || a == 0) return '0;
        if (m_hit(a)) return wr_data;
        return m_mem[a];
    endfunction

    function automatic logic m_busy(input logic [AW-1:0] a);
        return (m_done == NREGS) && (a != 0) && m_pend[a] && !m_hit(a);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            chk("init_busy", {31'b0, init_busy}, {31'b0, (m_done < NREGS)});
            for (int p = 0; p < NRD; p++) begin
                chk($sformatf("rd_data[%0d]", p), rd_data[p*XLEN +: XLEN], m_data(rd_addr[p*AW +: AW]));
                chk($sformatf("rd_busy[%0d]", p), {31'b0, rd_busy[p]}, {31'b0, m_busy(rd_addr[p*AW +: AW])});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setrd(input int a0, input int a1);
        rd_addr = {a1[AW-1:0], a0[AW-1:0]};
    endtask

    task automatic count_init(input string name);
        int n = 0;
        while (init_busy === 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk(name, n, 32);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        return ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, NREGS-1)) : AW'($urandom_range(0, 7));
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        #2 reset = 1'b0;
        mon_en = 1'b1;
        setrd(5, 0);
        repeat (3) step();
        @(negedge clk);
        chk("reset init_busy", {31'b0, init_busy}, 32'd1);
        chk("reset rd_data", rd_data[XLEN-1:0], 32'd0);
        chk("reset rd_busy", {30'b0, rd_busy}, 32'd0);
        step();
        reset = 1'b1;
        count_init("init edge count");

        // Every register reads zero after the clear.
        for (int r = 0; r < NREGS; r += 2) begin
            setrd(r, r + 1);
            @(negedge clk);
            chk("cleared reg", rd_data[XLEN-1:0] | rd_data[2*XLEN-1:XLEN], 32'd0);
            step();
        end

        wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; setrd(5, 5);
        @(negedge clk);
        chk("x5 same-cycle", rd_data[XLEN-1:0], BYP ? 32'hDEADBEEF : 32'd0);
        step();
        wr_en = 1'b0;
        @(negedge clk);
        chk("x5 port0", rd_data[XLEN-1:0], 32'hDEADBEEF);
        chk("x5 port1", rd_data[2*XLEN-1:XLEN], 32'hDEADBEEF);
        step();

        wr_en = 1'b1; wr_addr = 0; wr_data = 32'h12345678;
        issue_valid = 1'b1; issue_rd = 0; setrd(0, 0);
        @(negedge clk);
        chk("x0 write data", rd_data[XLEN-1:0], 32'd0);
        step();
        wr_en = 1'b0; issue_valid = 1'b0;
        @(negedge clk);
        chk("x0 after data", rd_data[XLEN-1:0], 32'd0);
        chk("x0 after busy", {30'b0, rd_busy}, 32'd0);
        step();

        issue_valid = 1'b1; issue_rd = 7; setrd(7, 3);
        step();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("x7 pending busy", {31'b0, rd_busy[0]}, 32'd1);
        step();
        wr_en = 1'b1; wr_addr = 7; wr_data = 32'hA5;
        @(negedge clk);
        chk("x7 wb-cycle busy", {31'b0, rd_busy[0]}, BYP ? 32'd0 : 32'd1);
        chk("x7 wb-cycle data", rd_data[XLEN-1:0], BYP ? 32'hA5 : 32'd0);
        step();
        wr_en = 1'b0;
        @(negedge clk);
        chk("x7 after busy", {31'b0, rd_busy[0]}, 32'd0);
        chk("x7 after data", rd_data[XLEN-1:0], 32'hA5);
        step();

        issue_valid = 1'b1; issue_rd = 9; wr_en = 1'b1; wr_addr = 9; wr_data = 32'h1; setrd(9, 9);
        step();
        issue_valid = 1'b0; wr_en = 1'b0;
        @(negedge clk);
        chk("x9 set-wins busy", {31'b0, rd_busy[1]}, 32'd1);
        chk("x9 data", rd_data[2*XLEN-1:XLEN], 32'h1);
        step();

        // Reset in the middle of the clear sequence.
        reset = 1'b0;
        step();
        reset = 1'b1;
        repeat (10) step();
        reset = 1'b0;
        @(negedge clk);
        chk("mid-init reset busy", {31'b0, init_busy}, 32'd1);
        step();
        reset = 1'b1;
        count_init("restart edge count");

        issue_valid = 1'b1; issue_rd = 3; setrd(3, 3);
        step();
        issue_valid = 1'b0;
        @(negedge clk);
        chk("x3 pending", {30'b0, rd_busy}, 32'd3);
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        count_init("run reset edge count");
        @(negedge clk);
        chk("x3 after reset data", rd_data[XLEN-1:0], 32'd0);
        chk("x3 after reset busy", {30'b0, rd_busy}, 32'd0);
        step();

        for (int c = 0; c < 700; c++) begin
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = rand_addr();
            wr_en       = ($urandom_range(0, 1) == 0);
            wr_addr     = rand_addr();
            wr_data     = $urandom;
            for (int p = 0; p < NRD; p++)
                rd_addr[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? wr_addr : rand_addr();
            reset = ($urandom_range(0, 299) != 0);
            step();
        end
        reset = 1'b1;
        wr_en = 1'b0;
        issue_valid = 1'b0;
        step();
        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/register_file_mp.md
# register_file_mp

Parametrised multi-read-port register file for the RV32I pipeline, replacing the fixed 2-read/1-write block in the decode/writeback path. It adds:
- a post-reset hardware clear sequence,
- a write-through bypass from the writeback port,
- a per-register pending-write scoreboard that the hazard unit uses to stall decode.

Register 0 reads as zero and is never written or marked pending.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, ≥4)
- NRD, 2, number of read ports
- AW, $clog2(NREGS), address width (derived; not overridden)

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- rd_addr_i  in  NRD×AW  read addresses
- rd_data_o  out  NRD×XLEN  read data (combinational)
- rd_busy_o  out  NRD  addressed register has a write outstanding
- issue_valid_i  in  1  decode issues an instruction writing issue_rd_i
- issue_rd_i  in  AW  destination of issued instruction
- wr_en_i  in  1  writeback write enable
- wr_addr_i  in  AW  writeback destination
- wr_data_i  in  XLEN  writeback data
- init_busy_o  out  1  clear sequence in progress; pipeline must hold

## Operation
- FSM states: INIT and RUN.
- Reset asserted:
  - state=INIT, clear counter=0, all pending bits=0.
  - init_busy_o=1, rd_busy_o=0, rd_data_o=0.
- INIT:
  - Each cycle, writes 0 to entry[counter] and increments the counter.
  - The cycle counter==NREGS-1 is written, the state moves to RUN.
  - wr_en_i and issue_valid_i are ignored; rd_data_o=0; rd_busy_o=0.
- RUN:
  - Write: wr_en_i && wr_addr_i!=0 → entry[wr_addr_i]<=wr_data_i.
  - Read, per port p: addr==0 → 0. Otherwise, a bypass hit (see Configuration) → wr_data_i; else entry[addr].
  - Issue: issue_valid_i && issue_rd_i!=0 → pending[issue_rd_i]<=1.
  - Writeback: wr_en_i && wr_addr_i!=0 → pending[wr_addr_i]<=0.
  - Issue and writeback to the same address in the same cycle: set wins, so the pending bit stays 1 for the younger instruction.
  - rd_busy_o[p] = pending[rd_addr_i[p]] && rd_addr_i[p]!=0, masked by the bypass rule below.
- Duplicate addresses across read ports are legal; each port is resolved independently.
- Reset asserted mid-INIT or mid-RUN restarts INIT from entry 0. Pending state is discarded.

## Timing
- Reads have zero latency (combinational from rd_addr_i and state).
- Writes are visible to the non-bypassed read path one cycle after wr_en_i.
- Clear sequence:
  - init_busy_o stays 1 for exactly NREGS rising edges after reset deasserts.
  - It drops after the edge that clears entry NREGS-1.
- A pending bit set at edge N drives rd_busy_o=1 from cycle N+1.

## Configuration
- REGFILE_BYPASS_EN defined:
  - In RUN, a read port whose non-zero address equals wr_addr_i while wr_en_i=1 returns wr_data_i.
  - That port's rd_busy_o is forced to 0 in that cycle.
- Undefined:
  - No bypass; the port returns the stored value.
  - rd_busy_o stays 1 until the cycle after the write, giving one extra stall cycle per RAW hazard.

## Structure
- regfile_pkg holds:
  - XLEN_DEFAULT, NREGS_DEFAULT
  - enum rf_state_e {RF_INIT, RF_RUN}
  - the address typedef rf_addr_t sized from NREGS_DEFAULT
- Sub-module regfile_scoreboard holds the pending vector with its set/clear/priority logic and the per-port busy lookup. Parameters are NREGS and NRD.
- Storage, the clear FSM and the bypass muxes stay in register_file_mp.

## Test plan
1. Reset then release; count edges → init_busy_o=1 for 32 edges, then 0. Read all 32 registers → 0.
2. RUN: write x5=0xDEADBEEF. With bypass, same-cycle read of x5 → 0xDEADBEEF. Next cycle read → 0xDEADBEEF on both ports.
3. Write x0=0x12345678 and issue x0 → reads of x0 return 0; rd_busy_o stays 0.
4. Issue x7, then read x7 → rd_busy_o=1. Writeback x7=0xA5 with bypass → busy=0 and data 0xA5 that cycle. Without bypass → busy=1 that cycle, 0 the next.
5. Same cycle: issue x9 and writeback x9=0x1 → pending[x9] remains 1 next cycle. Data reads 0x1.
6. Assert reset during INIT at counter=10, and again in RUN with x3 pending → init_busy_o restarts a full 32-edge sequence. x3 reads 0 with busy=0 afterwards.
